// File: rtl/sonic_pkg.sv
// Shared definitions for the ultrasonic echo emulator and its driver side:
// FSM state encoding and default timing constants at a 5 MHz clock.
package sonic_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TRIG_HI = 3'd1,
    BURST   = 3'd2,
    ECHO    = 3'd3,
    HOLD    = 3'd4
  } state_t;

  localparam int DEF_WIDTH      = 30;
  localparam int DEF_TRIG_MIN   = 50;      // 10 us
  localparam int DEF_ECHO_DELAY = 1000;    // 200 us burst time
  localparam int DEF_ECHO_MAX   = 190000;  // 38 ms, "no object"
  localparam int DEF_HOLDOFF    = 250;     // 50 us re-arm guard

endpackage

// File: rtl/sonic_echo_emulator_if.sv
// Signal bundle between a ranging driver (master) and the echo emulator (slave).
interface sonic_echo_emulator_if #(
  parameter int WIDTH = 30
);
  import sonic_pkg::*;

  // Pulse protocol, no valid/ready: master raises trig for >= TRIG_MIN cycles
  // with echo_width stable at the trig fall; slave answers with one echo pulse
  // of the latched length. trig is ignored while busy; echo_width may change
  // freely once the shot is latched.
  logic             trig;
  logic [WIDTH-1:0] echo_width;
  logic             echo;
  logic             busy;
  logic             trig_err;
  logic             shot_done;
  state_t           state;

  modport master (
    output trig, echo_width,
    input  echo, busy, trig_err, shot_done, state
  );

  modport slave (
    input  trig, echo_width,
    output echo, busy, trig_err, shot_done, state
  );

endinterface

// File: rtl/sonic_sync.sv
// Two-flop synchroniser for a single asynchronous level; reset clears both flops.
module sonic_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sonic_echo_emulator.sv
// Emulates an ultrasonic ranging sensor: validates the trig pulse, waits the
// burst time, then returns an echo pulse whose length encodes the distance.
module sonic_echo_emulator
  import sonic_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int TRIG_MIN   = DEF_TRIG_MIN,
  parameter int ECHO_DELAY = DEF_ECHO_DELAY,
  parameter int ECHO_MAX   = DEF_ECHO_MAX,
  parameter int HOLDOFF    = DEF_HOLDOFF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sonic_echo_emulator_if.slave  bus
);

  localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);
  localparam logic [WIDTH-1:0] ONES       = '1;
  localparam logic [WIDTH-1:0] TRIG_MIN_C = WIDTH'(TRIG_MIN);
  localparam logic [WIDTH-1:0] DELAY_C    = WIDTH'(ECHO_DELAY);
  localparam logic [WIDTH-1:0] MAX_C      = WIDTH'(ECHO_MAX);
  localparam logic [WIDTH-1:0] HOLD_C     = WIDTH'(HOLDOFF);

  logic             trig_s;
  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] len_q;
  logic             echo_q;
  logic             busy_q;
  logic             trig_err_q;
  logic             shot_done_q;

  sonic_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.trig),
    .q     (trig_s)
  );

  // One counter serves every timed phase; it always restarts at 1 on entry so
  // that a phase of length N ends on the cycle the count equals N.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      len_q       <= '0;
      echo_q      <= 1'b0;
      busy_q      <= 1'b0;
      trig_err_q  <= 1'b0;
      shot_done_q <= 1'b0;
    end else begin
      trig_err_q  <= 1'b0;
      shot_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (trig_s) begin
            state  <= TRIG_HI;
            cnt    <= ONE;
            busy_q <= 1'b1;
          end
        end
        TRIG_HI: begin
          if (trig_s) begin
            if (cnt != ONES) cnt <= cnt + ONE;
          end else if (cnt >= TRIG_MIN_C) begin
            state <= BURST;
            cnt   <= ONE;
            // Zero means no object; anything beyond the sensor range clamps.
            if (bus.echo_width == '0 || bus.echo_width > MAX_C) len_q <= MAX_C;
            else                                                len_q <= bus.echo_width;
          end else begin
            state      <= IDLE;
            cnt        <= '0;
            busy_q     <= 1'b0;
            trig_err_q <= 1'b1;
          end
        end
        BURST: begin
          if (cnt >= DELAY_C) begin
            state  <= ECHO;
            cnt    <= ONE;
            echo_q <= 1'b1;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        ECHO: begin
          if (cnt >= len_q) begin
            state       <= HOLD;
            cnt         <= ONE;
            echo_q      <= 1'b0;
            shot_done_q <= 1'b1;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        HOLD: begin
          if (cnt >= HOLD_C) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          echo_q <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.echo      = echo_q;
  assign bus.busy      = busy_q;
  assign bus.trig_err  = trig_err_q;
  assign bus.shot_done = shot_done_q;
  assign bus.state     = state;

endmodule

// File: tb/tb_sonic_echo_emulator.sv
// Bench for sonic_echo_emulator with shortened timing so clamp cases stay fast.
module tb_sonic_echo_emulator;
  import sonic_pkg::*;

  localparam int W  = 16;
  localparam int TM = 8;
  localparam int D  = 20;
  localparam int MX = 300;
  localparam int H  = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sonic_echo_emulator_if #(.WIDTH(W)) bus ();

  sonic_echo_emulator #(
    .WIDTH(W), .TRIG_MIN(TM), .ECHO_DELAY(D), .ECHO_MAX(MX), .HOLDOFF(H)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_err  = 0;
  int exp_errs = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Echo monitor: measures each pulse in whole cycles and compares to the queue.
  logic         prev_echo = 1'b0;
  int           cur_len = 0;
  logic [W-1:0] e;
  always @(negedge clk) begin
    if (bus.trig_err) n_err++;
    if (bus.shot_done && !(prev_echo && !bus.echo)) check("shot_done_spurious", 1, 0);
    if (bus.echo) begin
      if (!prev_echo) cur_len = 0;
      cur_len++;
    end else if (prev_echo && rst_n) begin
      check("shot_done_at_fall", bus.shot_done, 1);
      if (exp_q.size() == 0) check("unexpected_shot", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("echo_len", cur_len, e);
      end
    end
    prev_echo = bus.echo;
  end

  task automatic wait_idle();
    int k = 0;
    while (bus.busy && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (bus.busy) check("wait_idle_timeout", 1, 0);
  endtask

  task automatic do_shot(input int n, input int w, input bit exp_err, input int exp_len,
                         input int chg, input bit retrig);
    int t0, k, f, errs0;
    wait_idle();
    repeat (2) @(negedge clk);
    errs0 = n_err;
    bus.echo_width = W'(w);
    bus.trig = 1'b1;
    t0 = cyc;
    repeat (n) @(negedge clk);
    bus.trig = 1'b0;
    if (exp_err) begin
      exp_errs++;
      k = 0;
      while (!bus.trig_err && k < 50) begin
        @(negedge clk);
        k++;
      end
      check("trig_err_time", cyc - t0, n + 3);
      check("busy_after_err", bus.busy, 0);
      @(negedge clk);
      check("trig_err_one_cycle", bus.trig_err, 0);
      check("echo_after_err", bus.echo, 0);
    end else begin
      exp_q.push_back(W'(exp_len));
      k = 0;
      while (!bus.echo && k < n + D + 50) begin
        @(negedge clk);
        k++;
        if (chg >= 0 && k == 5) bus.echo_width = W'(chg);
      end
      check("echo_rise_time", cyc - t0, n + 3 + D);
      if (retrig) begin
        repeat (3) @(negedge clk);
        bus.trig = 1'b1;
        repeat (TM + 2) @(negedge clk);
        bus.trig = 1'b0;
      end
      k = 0;
      while (!bus.shot_done && k < MX + 50) begin
        @(negedge clk);
        k++;
      end
      f = cyc;
      k = 0;
      while (bus.busy && k < H + 50) begin
        @(negedge clk);
        k++;
      end
      check("holdoff_len", cyc - f, H);
      check("no_trig_err_in_shot", n_err - errs0, 0);
    end
  endtask

  typedef struct {
    int trig_len;
    int width;
    bit err;
    int exp_len;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int k;
    vecs[0] = '{TM,      58,    1'b0, 58};
    vecs[1] = '{TM - 1,  58,    1'b1, 0};
    vecs[2] = '{TM,      0,     1'b0, MX};
    vecs[3] = '{TM + 2,  MX + 1, 1'b0, MX};
    vecs[4] = '{TM + 1,  MX,    1'b0, MX};
    vecs[5] = '{20,      1,     1'b0, 1};
    vecs[6] = '{1,       5,     1'b1, 0};
    vecs[7] = '{TM,      MX - 1, 1'b0, MX - 1};
    vecs[8] = '{30,      65535, 1'b0, MX};

    bus.trig = 1'b0;
    bus.echo_width = '0;
    repeat (3) @(negedge clk);
    check("rst_echo", bus.echo, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_trig_err", bus.trig_err, 0);
    check("rst_shot_done", bus.shot_done, 0);
    check("rst_state", int'(bus.state), int'(IDLE));
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      do_shot(vecs[i].trig_len, vecs[i].width, vecs[i].err, vecs[i].exp_len, -1, 1'b0);

    for (int i = 0; i < 3; i++) begin
      int w = $urandom_range(1, MX);
      do_shot($urandom_range(TM, TM + 10), w, 1'b0, w, -1, 1'b0);
    end

    // Width change during the burst and a re-trigger during echo must not matter.
    do_shot(TM, 58, 1'b0, 58, 5, 1'b1);

    // Reset in mid-echo, with trig already high when reset releases.
    wait_idle();
    @(negedge clk);
    bus.echo_width = W'(200);
    bus.trig = 1'b1;
    repeat (TM) @(negedge clk);
    bus.trig = 1'b0;
    k = 0;
    while (!bus.echo && k < D + 50) begin
      @(negedge clk);
      k++;
    end
    check("pre_reset_echo", bus.echo, 1);
    repeat (50) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("reset_drops_echo", bus.echo, 0);
    check("reset_drops_busy", bus.busy, 0);
    check("reset_state_idle", int'(bus.state), int'(IDLE));
    bus.trig = 1'b1;
    bus.echo_width = W'(77);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(W'(77));
    repeat (TM) @(negedge clk);
    bus.trig = 1'b0;
    k = 0;
    while (!bus.busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("fresh_edge_after_reset", bus.busy, 1);
    repeat (5) @(negedge clk);
    wait_idle();

    do_shot(TM, 123, 1'b0, 123, -1, 1'b0);
    wait_idle();
    repeat (5) @(negedge clk);
    check("pending_shots", exp_q.size(), 0);
    check("total_trig_err", n_err, exp_errs);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish (passed %0d of %0d)", n_pass, n_chk);
    $fatal(1);
  end

endmodule
